// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready on both sides, a single registered
// result slot and an iterative (one bit per cycle) shift-add multiplier.
// Optional feature macro: ALU_SEQ_OVERFLOW_EN (registered signed-overflow flag).
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. in_ready = IDLE && (slot empty || slot being
// taken), so a result can leave and a new op enter on the same edge. in_valid
// and the operands are only sampled on an accepting edge.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_LTU = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_LT  = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1101;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_mul_a;
  logic [WIDTH-1:0] r_mul_b;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic             w_take;
  logic             w_is_mul;
  logic             w_mul_last;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_mul_sum;

  assign w_is_mul   = (alu_op == OP_MUL);
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == '0);
  assign w_accept   = in_valid && in_ready;
  assign w_take     = r_out_valid && out_ready;
  assign w_sh       = op2[SHW-1:0];
  assign w_mul_sum  = r_acc + (r_mul_b[0] ? r_mul_a : '0);

  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign zero       = r_zero;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and input-side ready
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = !r_out_valid || out_ready;
        if (in_valid && in_ready && w_is_mul) w_state_nxt = S_MUL;
      end
      S_MUL: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle operations; MUL and undefined codes fall through to ADD
  always_comb begin
    w_alu_res = '0;
    case (alu_op)
      OP_AND:  w_alu_res = op1 & op2;
      OP_OR:   w_alu_res = op1 | op2;
      OP_LTU:  w_alu_res[0] = (op1 < op2);
      OP_SUB:  w_alu_res = op1 - op2;
      OP_LT:   w_alu_res[0] = ($signed(op1) < $signed(op2));
      OP_SRL:  w_alu_res = op1 >> w_sh;
      OP_SLL:  w_alu_res = op1 << w_sh;
      OP_SRA:  w_alu_res = $unsigned($signed(op1) >>> w_sh);
      OP_XOR:  w_alu_res = op1 ^ op2;
      default: w_alu_res = op1 + op2;
    endcase
  end

  // Result slot and multiplier datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_cnt       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_acc       <= '0;
    end else begin
      if (w_take) r_out_valid <= 1'b0;
      if (r_state == S_MUL) begin
        // one multiplier bit per cycle, LSB first
        r_acc   <= w_mul_sum;
        r_mul_a <= r_mul_a << 1;
        r_mul_b <= r_mul_b >> 1;
        if (r_cnt == '0) begin
          r_result    <= w_mul_sum;
          r_zero      <= (w_mul_sum == '0);
          r_out_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt - SHW'(1);
        end
      end else if (w_accept) begin
        if (w_is_mul) begin
          r_mul_a <= op1;
          r_mul_b <= op2;
          r_acc   <= '0;
          r_cnt   <= SHW'(WIDTH - 1);
        end else begin
          r_result    <= w_alu_res;
          r_zero      <= (w_alu_res == '0);
          r_out_valid <= 1'b1;
        end
      end
    end
  end

`ifdef ALU_SEQ_OVERFLOW_EN
  logic w_alu_ovf;
  logic r_overflow;

  // Signed overflow; every code that computes ADD uses the add rule
  always_comb begin
    w_alu_ovf = 1'b0;
    case (alu_op)
      OP_AND, OP_OR, OP_LTU, OP_MUL, OP_LT,
      OP_SRL, OP_SLL, OP_SRA, OP_XOR: w_alu_ovf = 1'b0;
      OP_SUB:  w_alu_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                           (w_alu_res[WIDTH-1] != op1[WIDTH-1]);
      default: w_alu_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                           (w_alu_res[WIDTH-1] != op1[WIDTH-1]);
    endcase
  end

  // Overflow flag written alongside the result slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_mul_last) begin
      r_overflow <= 1'b0;
    end else if ((r_state == S_IDLE) && w_accept && !w_is_mul) begin
      r_overflow <= w_alu_ovf;
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq at WIDTH 32, 16 and 8.
module tb_alu_seq;

`ifdef ALU_SEQ_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // per-instance stimulus: index 0 -> WIDTH 32, 1 -> WIDTH 16, 2 -> WIDTH 8
  logic        in_valid_a [3];
  logic        out_ready_a[3];
  logic [31:0] op1_a      [3];
  logic [31:0] op2_a      [3];
  logic [3:0]  alu_op_a   [3];

  logic        rdy32, ov32, z32, of32;
  logic [31:0] res32;
  logic        rdy16, ov16, z16, of16;
  logic [15:0] res16;
  logic        rdy8, ov8, z8, of8;
  logic [7:0]  res8;

  logic        rdy_a[3];
  logic        ov_a [3];
  logic        z_a  [3];
  logic        of_a [3];
  logic [31:0] res_a[3];

  always_comb begin
    rdy_a[0] = rdy32; ov_a[0] = ov32; z_a[0] = z32; of_a[0] = of32; res_a[0] = res32;
    rdy_a[1] = rdy16; ov_a[1] = ov16; z_a[1] = z16; of_a[1] = of16; res_a[1] = {16'd0, res16};
    rdy_a[2] = rdy8;  ov_a[2] = ov8;  z_a[2] = z8;  of_a[2] = of8;  res_a[2] = {24'd0, res8};
  end

  alu_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(rdy32),
    .op1(op1_a[0]), .op2(op2_a[0]), .alu_op(alu_op_a[0]),
    .out_valid(ov32), .out_ready(out_ready_a[0]), .result(res32),
    .zero(z32), .overflow(of32));

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(rdy16),
    .op1(op1_a[1][15:0]), .op2(op2_a[1][15:0]), .alu_op(alu_op_a[1]),
    .out_valid(ov16), .out_ready(out_ready_a[1]), .result(res16),
    .zero(z16), .overflow(of16));

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(rdy8),
    .op1(op1_a[2][7:0]), .op2(op2_a[2][7:0]), .alu_op(alu_op_a[2]),
    .out_valid(ov8), .out_ready(out_ready_a[2]), .result(res8),
    .zero(z8), .overflow(of8));

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // drive one op with out_ready=1, confirm it is accepted on the next edge
  task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid_a[i]  = 1'b1;
    alu_op_a[i]    = op;
    op1_a[i]       = a;
    op2_a[i]       = b;
    out_ready_a[i] = 1'b1;
    #1;
    chk($sformatf("in_ready_before_op%0d", op), {31'd0, rdy_a[i]}, 32'd1);
    tick();
    in_valid_a[i] = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Works on w-bit values as plain integers; returns {overflow, result}.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    longint unsigned m, ua, ub, r;
    longint          sa, sb, s, hi, lo;
    int              sh;
    bit              ov;
    m  = (64'd1 << w) - 64'd1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = longint'(ua);
    if (((ua >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
    sb = longint'(ub);
    if (((ub >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
    sh = int'(ub % longint'(w));
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    ov = 1'b0;
    case (op)
      4'd0:  r = ua & ub;
      4'd1:  r = ua | ub;
      4'd3:  r = (ua < ub) ? 64'd1 : 64'd0;
      4'd4:  r = ua * ub;
      4'd6:  begin s = sa - sb; r = s; ov = (s > hi) || (s < lo); end
      4'd7:  r = (sa < sb) ? 64'd1 : 64'd0;
      4'd8:  r = ua >> sh;
      4'd9:  r = ua << sh;
      4'd10: r = sa >>> sh;
      4'd13: r = ua ^ ub;
      default: begin s = sa + sb; r = s; ov = (s > hi) || (s < lo); end
    endcase
    r = r & m;
    return {ov, r[31:0]};
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] m, input int w);
    case ($urandom_range(7, 0))
      0: return m;
      1: return 32'd0;
      2: return (32'd1 << (w - 1)) & m;
      3: return 32'(w);
      default: return $urandom & m;
    endcase
  endfunction

  // ---------------- randomized scoreboard run ----------------
  task automatic run_random(input int i, input int w, input int n_ops);
    logic [32:0] exp_q[$];
    logic [31:0] m, a, b;
    logic [3:0]  op;
    logic [32:0] r;
    bit          exp_valid, exp_rdy, acc, take;
    int          busy, accepted, cycles;
    m         = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    exp_valid = 1'b0;
    busy      = 0;
    accepted  = 0;
    cycles    = 0;
    while (accepted < n_ops && cycles < 20000) begin
      op             = 4'($urandom_range(15, 0));
      a              = pick(m, w);
      b              = pick(m, w);
      in_valid_a[i]  = ($urandom_range(3, 0) != 0);
      out_ready_a[i] = ($urandom_range(2, 0) != 0);
      alu_op_a[i]    = op;
      op1_a[i]       = a;
      op2_a[i]       = b;
      #1;
      exp_rdy = (busy == 0) && (!exp_valid || out_ready_a[i]);
      chk("rand_in_ready", {31'd0, rdy_a[i]}, {31'd0, exp_rdy});
      acc  = in_valid_a[i] && exp_rdy;
      take = exp_valid && out_ready_a[i];
      r    = model(op, a, b, w);
      tick();
      cycles++;
      if (take) begin
        exp_valid = 1'b0;
        void'(exp_q.pop_front());
      end
      if (busy > 0) begin
        busy--;
        if (busy == 0) exp_valid = 1'b1;
      end
      if (acc) begin
        exp_q.push_back(r);
        accepted++;
        if (op == 4'd4) busy = w;
        else            exp_valid = 1'b1;
      end
      chk("rand_out_valid", {31'd0, ov_a[i]}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk($sformatf("rand_result_w%0d", w), res_a[i], exp_q[0][31:0]);
        chk("rand_zero", {31'd0, z_a[i]}, {31'd0, (exp_q[0][31:0] == 32'd0)});
        chk("rand_overflow", {31'd0, of_a[i]}, {31'd0, exp_q[0][32] & OVF_ON});
      end
    end
    in_valid_a[i]  = 1'b0;
    out_ready_a[i] = 1'b1;
    chk("rand_ops_accepted", 32'(accepted), 32'(n_ops));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b0;
      op1_a[i]       = '0;
      op2_a[i]       = '0;
      alu_op_a[i]    = '0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, ov_a[0]}, 32'd0);
    chk("rst_result",    res_a[0], 32'd0);
    chk("rst_zero",      {31'd0, z_a[0]}, 32'd1);
    chk("rst_overflow",  {31'd0, of_a[0]}, 32'd0);
    chk("rst_in_ready",  {31'd0, rdy_a[0]}, 32'd1);
    chk("rst_zero_w8",   {31'd0, z_a[2]}, 32'd1);

    // ADD with signed overflow, latency 1
    issue(0, 4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_result",    res_a[0], 32'h8000_0000);
    chk("add_zero",      {31'd0, z_a[0]}, 32'd0);
    chk("add_out_valid", {31'd0, ov_a[0]}, 32'd1);
    chk("add_overflow",  {31'd0, of_a[0]}, {31'd0, OVF_ON});

    // shift by WIDTH is shift by 0; signed vs unsigned compare
    issue(0, 4'd10, 32'hFFFF_0000, 32'h0000_0020);
    chk("sra_by_width", res_a[0], 32'hFFFF_0000);
    issue(0, 4'd7, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("lt_signed", res_a[0], 32'd1);
    issue(0, 4'd3, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("ltu_unsigned", res_a[0], 32'd0);
    chk("ltu_zero", {31'd0, z_a[0]}, 32'd1);

    // MUL: busy WIDTH cycles, result WIDTH cycles after accept
    issue(0, 4'd4, 32'h0000_1234, 32'h0000_0005);
    chk("mul_busy_c0", {31'd0, rdy_a[0]}, 32'd0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k < 32) begin
        chk($sformatf("mul_busy_c%0d", k), {31'd0, rdy_a[0]}, 32'd0);
        chk("mul_no_early_valid", {31'd0, ov_a[0]}, 32'd0);
      end else begin
        chk("mul_valid_at_w", {31'd0, ov_a[0]}, 32'd1);
        chk("mul_result", res_a[0], 32'h0000_5B04);
      end
    end
    tick();
    chk("mul_taken", {31'd0, ov_a[0]}, 32'd0);

    // WIDTH=8 MUL wraps
    issue(2, 4'd4, 32'h0000_00FF, 32'h0000_00FF);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) chk("mul8_no_early_valid", {31'd0, ov_a[2]}, 32'd0);
      else begin
        chk("mul8_valid_at_w", {31'd0, ov_a[2]}, 32'd1);
        chk("mul8_result", res_a[2], 32'h0000_0001);
      end
    end
    tick();

    // backpressure: SUB 5-5 held, then take + new AND on the same edge
    issue(0, 4'd6, 32'd5, 32'd5);
    out_ready_a[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_in_ready", {31'd0, rdy_a[0]}, 32'd0);
      tick();
      chk("hold_out_valid", {31'd0, ov_a[0]}, 32'd1);
      chk("hold_result", res_a[0], 32'd0);
      chk("hold_zero", {31'd0, z_a[0]}, 32'd1);
    end
    issue(0, 4'd0, 32'h0000_F0F0, 32'h0000_FF00);
    chk("and_after_take_valid", {31'd0, ov_a[0]}, 32'd1);
    chk("and_after_take_result", res_a[0], 32'h0000_F000);
    chk("and_after_take_zero", {31'd0, z_a[0]}, 32'd0);
    tick();
    chk("and_taken", {31'd0, ov_a[0]}, 32'd0);

    // reset during MUL abandons it
    issue(0, 4'd4, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready_a[0] = 1'b0;
    #1;
    chk("mulrst_out_valid", {31'd0, ov_a[0]}, 32'd0);
    chk("mulrst_result",    res_a[0], 32'd0);
    chk("mulrst_zero",      {31'd0, z_a[0]}, 32'd1);
    chk("mulrst_in_ready",  {31'd0, rdy_a[0]}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("mulrst_no_stale", {31'd0, ov_a[0]}, 32'd0);
    end

    // random scoreboard runs at two widths
    run_random(0, 32, 250);
    run_random(1, 16, 250);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised sequential successor to the lab ALU. Same 4-bit opcode set; adds an unsigned compare and an iterative multiply.
- Valid/ready handshakes on both the input and output sides. One registered result slot.
- Sits between the operand-fetch and writeback stages of the multi-cycle datapath. A multiply stalls upstream until its result has been taken.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount field width; derived, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  op1/op2/alu_op are valid this cycle
- in_ready  output  1  block accepts an operation this cycle
- op1  input  WIDTH  operand A
- op2  input  WIDTH  operand B
- alu_op  input  4  operation select
- out_valid  output  1  result/zero hold a valid, untaken result
- out_ready  input  1  consumer takes the result this cycle
- result  output  WIDTH  registered result
- zero  output  1  registered flag: (result == 0)
- overflow  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Opcodes:
  - AND 0000; OR 0001; ADD 0010; LTU 0011 (unsigned op1<op2 -> 1, else 0); MUL 0100 (low WIDTH bits of op1*op2)
  - SUB 0110; LT 0111 (signed, result 1/0); SRL 1000; SLL 1001; SRA 1010; XOR 1101
  - Any other code computes ADD.
- Shifts use op2[SHW-1:0] only; upper bits of op2 are ignored (shift by WIDTH means shift by 0). Add and sub wrap modulo 2^WIDTH.
- Handshake:
  - Accept = in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). This lets the output be taken and a new operation accepted in the same cycle (back-to-back throughput of 1 for non-MUL ops).
- Output slot:
  - Holds the result while out_valid && !out_ready; result, zero and overflow are stable during the hold.
  - out_valid clears on the edge where out_valid && out_ready, unless a new result is written on that same edge.
- State machine:
  - IDLE: accepting a non-MUL op writes the output slot at the same edge, so latency is 1 and out_valid=1 in the next cycle. Accepting MUL latches the operands, clears the accumulator, loads the counter with WIDTH-1, and moves to MUL.
  - MUL: shift-add, one operand bit per cycle (LSB first), counter decrements each cycle, in_ready=0. When the counter reaches 0, the final partial sum is written to the output slot, out_valid is set, and the state returns to IDLE.
  - MUL latency: the result is valid WIDTH cycles after the accept edge.
  - Inputs are not sampled outside an accept; operand changes during MUL have no effect.
- Reset:
  - Values: state=IDLE, out_valid=0, result=0, zero=1, overflow=0, counter=0.
  - Reset mid-MUL abandons the operation with no output produced. Reset has priority over every other event.
- zero is computed from the value written into the slot, never combinationally from the inputs.

Optional Feature:
- Macro ALU_SEQ_OVERFLOW_EN.
- Defined: overflow is registered with the result.
  - ADD: 1 when the operand signs are equal and the result sign differs.
  - SUB: 1 when the operand signs differ and the result sign differs from op1's sign.
  - 0 for all other ops.
- Undefined: the overflow port still exists, is tied 0, and no overflow logic is synthesised.

Test Plan:
- Reset, then ADD 32'h7FFFFFFF + 32'h00000001 with out_ready=1 -> next cycle result=32'h80000000, zero=0, out_valid=1; overflow=1 only with the macro defined.
- SRA 32'hFFFF0000 by op2=32'h00000020 -> result=32'hFFFF0000 (shift 0); LT FFFFFFFF vs 00000001 -> 1; LTU on the same operands -> 0.
- MUL 32'h00001234 * 32'h00000005 -> in_ready=0 for 32 cycles, out_valid exactly 32 cycles after accept, result=32'h00005B04. With WIDTH=8: 8'hFF * 8'hFF -> 8'h01 after 8 cycles.
- Backpressure: hold out_ready=0 after SUB 5-5 -> result=0 and zero=1 stable, in_ready=0. Raise out_ready with a new in_valid AND pending -> both complete on the same edge, and the AND result appears next cycle.
- Assert rst at cycle 10 of a MUL -> next cycle out_valid=0, result=0, zero=1, in_ready=1, and no stale product ever appears.
- Random: 500 ops across all opcodes with random in_valid/out_ready, checked against a scoreboard model for WIDTH=32 and WIDTH=16.
